// File: rtl/key_pkg.sv
// Shared state encoding and default timing constants for push-button debouncers.
// Latency/backpressure: none, declarations only.
package key_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } key_state_e;

    // 10 ms and 1 s at the 50 MHz board clock
    localparam int unsigned KEY_DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned KEY_LONG_DEFAULT     = 50000000;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous level input.
// Latency 2 clocks; no backpressure. Output resets to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic async_dat,
    output logic sync_dat
);

    logic meta_dat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_dat <= RST_VAL;
            sync_dat <= RST_VAL;
        end else begin
            meta_dat <= async_dat;
            sync_dat <= meta_dat;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: sync + counter debounce + press/release/long-press strobes for one active-low key.
// Latency: strobes DEBOUNCE_CYCLES+2 edges after the first sample; no backpressure (fire-and-forget strobes).
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = KEY_LONG_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             key_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             pressed_d, press_d, release_d, long_d;

    sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .async_dat (i_key_n),
        .sync_dat  (key_s)
    );

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        case (state_q)
            S_RELEASED: begin
                if (!key_s) begin
                    state_d  = S_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (key_s) begin
                    state_d  = S_RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = S_PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (key_s) begin
                    state_d  = S_RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = S_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_RELEASED;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_RELEASED;
        endcase

        // Hold time keeps running through release bounces so a blip cannot delay the long strobe;
        // a long strobe landing on the release edge is dropped to keep strobes exclusive.
        if (state_q == S_PRESSED || state_q == S_RELEASE_WAIT) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
            long_d = (hold_cnt_q == HOLD_LAST) && !release_d;
        end

        pressed_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= S_RELEASED;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            o_pressed       <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_long_pulse    <= 1'b0;
        end else begin
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            o_pressed       <= pressed_d;
            o_press_pulse   <= press_d;
            o_release_pulse <= release_d;
            o_long_pulse    <= long_d;
        end
    end

endmodule
